// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op/state encodings and widths for shift_iter (SHIFT_ITER_ROT_EN enables rotates)
package shift_pkg;

  localparam int SHIFT_WIDTH = 16;
  localparam int SHIFT_AMT_W = 4;

  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_ROR = 3'b001,
    OP_SLL = 3'b010,
    OP_SRA = 3'b011,
    OP_SRL = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } shift_state_e;

  // Rotates are only legal when the rotate datapath is built in.
  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SLL, OP_SRA, OP_SRL: ok = 1'b1;
`ifdef SHIFT_ITER_ROT_EN
      OP_ROL, OP_ROR:         ok = 1'b1;
`endif
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one 1- or 2-bit shift/rotate step (rotates only with SHIFT_ITER_ROT_EN)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       op_i,
  input  logic             two_i,
  output logic [WIDTH-1:0] data_o
);

  // Single step by k bits: k=2 when two_i, else k=1; unknown ops pass data through
  always_comb begin
    data_o = data_i;
    case (op_i)
`ifdef SHIFT_ITER_ROT_EN
      OP_ROL: data_o = two_i ? {data_i[WIDTH-3:0], data_i[WIDTH-1:WIDTH-2]}
                             : {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      OP_ROR: data_o = two_i ? {data_i[1:0], data_i[WIDTH-1:2]}
                             : {data_i[0], data_i[WIDTH-1:1]};
`endif
      OP_SLL: data_o = two_i ? {data_i[WIDTH-3:0], 2'b00}
                             : {data_i[WIDTH-2:0], 1'b0};
      OP_SRA: data_o = two_i ? {{2{data_i[WIDTH-1]}}, data_i[WIDTH-1:2]}
                             : {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      OP_SRL: data_o = two_i ? {2'b00, data_i[WIDTH-1:2]}
                             : {1'b0, data_i[WIDTH-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_iter.sv
// rtl/shift_iter.sv - multi-cycle shift/rotate unit with valid/ready in and out (SHIFT_ITER_ROT_EN enables rotates)
module shift_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int AMT_W = SHIFT_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic             step_two;
  logic [WIDTH-1:0] step_data;

  assign step_two = (rem_q > AMT_W'(1));

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .two_i  (step_two),
    .data_o (step_data)
  );

  // State and working registers; reset discards any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= 3'b000;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Next state: capture in IDLE, step the working reg in RUN, hold until taken in DONE
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          op_d    = in_op;
          rem_d   = in_amt;
          err_d   = !op_legal(in_op);
          state_d = ((in_amt == '0) || !op_legal(in_op)) ? DONE : RUN;
        end
      end
      RUN: begin
        data_d = step_data;
        rem_d  = rem_q - (step_two ? AMT_W'(2) : AMT_W'(1));
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registers or the state decode only
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_iter.sv
// tb/tb_shift_iter.sv - scoreboard bench for shift_iter (expectations follow SHIFT_ITER_ROT_EN)
module tb_shift_iter;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
    logic [7:0]  lat;
  } res_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] d;
    logic [3:0]  a;
    res_t        r;
  } vec_t;

`ifdef SHIFT_ITER_ROT_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic [2:0]  in_op = 3'b000;
  logic [3:0]  in_amt = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_err;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 1'b0;
  bit   rnd_en = 1'b0;
  logic [7:0] lat_q = 8'd0;
  res_t mon_r;
  res_t exp_q[$];
  res_t obs_q[$];

  shift_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency from accept cycle to first out_valid, result captured at handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !seen) begin
        lat_q = 8'(cyc - acc_cyc);
        seen  = 1'b1;
      end
      if (out_valid && out_ready) begin
        mon_r.d   = out_data;
        mon_r.e   = out_err;
        mon_r.lat = lat_q;
        obs_q.push_back(mon_r);
        seen = 1'b0;
      end
    end
  end

  function automatic res_t ref_model(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a);
    res_t r;
    logic [31:0] dd;
    logic legal;
    legal = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (ROT && (op <= 3'b001));
    dd = {d, d};
    r.d = d;
    r.e = !legal;
    r.lat = (legal && (a != 4'd0)) ? 8'(1 + (int'(a) + 1) / 2) : 8'd1;
    if (legal) begin
      case (op)
        3'b000: begin dd = dd << a; r.d = dd[31:16]; end
        3'b001: begin dd = dd >> a; r.d = dd[15:0]; end
        3'b010: r.d = d << a;
        3'b011: r.d = $signed(d) >>> a;
        default: r.d = d >> a;
      endcase
    end
    return r;
  endfunction

  // Present one request and hold it until accepted; scrambles in_* afterwards
  task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a);
    int n = 0;
    @(posedge clk); #1;
    in_op = op; in_data = d; in_amt = a; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 16'($urandom); in_op = 3'($urandom); in_amt = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_err !== 1'b0)    begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_data !== 16'h0)  begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t tab[8];
    res_t e, o;
    int n;
    tab[0] = '{3'b000, 16'h8001, 4'd3,  '{ROT ? 16'h000C : 16'h8001, !ROT, ROT ? 8'd3 : 8'd1}};
    tab[1] = '{3'b011, 16'h8000, 4'd5,  '{16'hFC00, 1'b0, 8'd4}};
    tab[2] = '{3'b100, 16'hF000, 4'd4,  '{16'h0F00, 1'b0, 8'd3}};
    tab[3] = '{3'b001, 16'h0001, 4'd15, '{ROT ? 16'h0002 : 16'h0001, !ROT, ROT ? 8'd9 : 8'd1}};
    tab[4] = '{3'b010, 16'h1234, 4'd0,  '{16'h1234, 1'b0, 8'd1}};
    tab[5] = '{3'b110, 16'hBEEF, 4'd5,  '{16'hBEEF, 1'b1, 8'd1}};
    tab[6] = '{3'b011, 16'h8000, 4'd15, '{16'hFFFF, 1'b0, 8'd9}};
    tab[7] = '{3'b011, 16'h7FFF, 4'd15, '{16'h0000, 1'b0, 8'd9}};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tab[i].r);
      send(tab[i].op, tab[i].d, tab[i].a);
      n = 0;
      while (obs_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL directed%0d_timeout no result, want %h", i, e.d);
      end else begin
        o = obs_q.pop_front();
        checks++; if (o.d !== e.d)     begin errors++; $display("FAIL directed%0d_data got %h want %h", i, o.d, e.d); end
        checks++; if (o.e !== e.e)     begin errors++; $display("FAIL directed%0d_err got %b want %b", i, o.e, e.e); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, o.lat, e.lat); end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t e, o;
    int n = 0;
    out_ready = 1'b0;
    exp_q.push_back('{16'h03FC, 1'b0, 8'd2});
    send(3'b010, 16'h00FF, 4'd2);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_done_timeout out_valid=%b want 1", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'b010; in_data = 16'hAAAA; in_amt = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_data !== 16'h03FC) begin errors++; $display("FAIL bp_hold%0d_data got %h want 03fc", i, out_data); end
      checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL bp_hold%0d_valid got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL bp_hold%0d_in_ready got %b want 0", i, in_ready); end
      checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL bp_hold%0d_busy got %b want 1", i, busy); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL bp_result_count got %0d want 1", obs_q.size()); end
    e = exp_q.pop_front();
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      checks++; if (o.d !== e.d) begin errors++; $display("FAIL bp_data got %h want %h", o.d, e.d); end
      checks++; if (o.e !== e.e) begin errors++; $display("FAIL bp_err got %b want %b", o.e, e.e); end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_run();
    res_t e, o;
    int n = 0;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
    send(3'b010, 16'h0001, 4'd9);
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrun_rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_err !== 1'b0)   begin errors++; $display("FAIL midrun_rst_out_err got %b want 0", out_err); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrun_rst_busy got %b want 0", busy); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL midrun_rst_out_data got %h want 0000", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{16'h0002, 1'b0, 8'd2});
    send(3'b010, 16'h0001, 4'd1);
    while (obs_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL midrun_after_timeout no result, want %h", e.d);
    end else begin
      o = obs_q.pop_front();
      checks++; if (o.d !== e.d)     begin errors++; $display("FAIL midrun_after_data got %h want %h", o.d, e.d); end
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL midrun_after_latency got %0d want %0d", o.lat, e.lat); end
    end
  endtask

  task automatic test_random();
    res_t e, o;
    int n;
    logic [2:0] op;
    logic [15:0] d;
    logic [3:0] a;
    rnd_en = 1'b1;
    fork
      begin
        while (rnd_en) begin
          @(posedge clk); #1;
          if (rnd_en) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      a  = 4'($urandom);
      exp_q.push_back(ref_model(op, d, a));
      send(op, d, a);
      n = 0;
      while (obs_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rand%0d_timeout no result, want %h", i, e.d);
      end else begin
        o = obs_q.pop_front();
        checks++; if (o.d !== e.d)     begin errors++; $display("FAIL rand%0d_data op=%0d amt=%0d in=%h got %h want %h", i, op, a, d, o.d, e.d); end
        checks++; if (o.e !== e.e)     begin errors++; $display("FAIL rand%0d_err op=%0d got %b want %b", i, op, o.e, e.e); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rand%0d_latency op=%0d amt=%0d got %0d want %0d", i, op, a, o.lat, e.lat); end
      end
    end
    rnd_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/shift_iter.md
# shift_iter

Multi-cycle sequential shift/rotate unit for the demo1 execute stage. It accepts a 16-bit operand, a shift op and a 4-bit shift amount over a valid/ready handshake. It then drives a 2-bit/1-bit shift step repeatedly until the full amount is applied, and returns the result over a second valid/ready handshake. It replaces a full barrel shifter where area matters, at the cost of variable latency.

## Interface
- WIDTH, 16, operand/result width.
- AMT_W, 4, shift-amount width; amount range 0..2^AMT_W-1.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- in_data  input  WIDTH  operand.
- in_op  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRA, 100 SRL, 101..111 illegal.
- in_amt  input  AMT_W  shift amount.
- out_valid  output  1  result present (high only in DONE).
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  result.
- out_err  output  1  op was illegal; qualified by out_valid.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture data/op/amt into the working regs and clear err. Go to DONE if amt==0 or the op is illegal, else go to RUN.
- Illegal op: out_data = captured in_data unchanged, out_err=1.
- RUN: each cycle, step = 2 if remaining>=2, else 1. Apply the step to the working reg and set remaining -= step. When the new remaining is 0, go to DONE.
- Step semantics by k bits (k=1 or 2):
  - ROL/ROR rotate.
  - SLL zero-fills the LSBs.
  - SRA fills with the current bit WIDTH-1.
  - SRL zero-fills the MSBs.
- Iterated steps compose exactly, so the result equals a single shift by amt. For SLL/SRL with amt>=WIDTH the result is 0; for SRA it is all sign bits. These cannot occur at the defaults.
- DONE: out_valid=1, and out_data/out_err hold steady until out_ready. On out_ready, go to IDLE.
- Requests are not accepted in DONE. There is no same-cycle turnaround, because in_ready is low in DONE.
- in_* inputs are ignored outside the IDLE accept cycle; a change mid-RUN has no effect.
- Reset (at any time, including mid-RUN or DONE):
  - state = IDLE, in_ready=1 (so in_ready is high during reset).
  - out_valid=0, out_err=0, busy=0, out_data=0.
  - Any in-flight result is discarded.

## Timing
- Accept in cycle T.
- Latency:
  - amt=0 or illegal op: out_valid first high at T+1.
  - otherwise: out_valid first high at T+1+ceil(amt/2) (amt=15 → T+9).
- Throughput: at most one request per (latency+1) cycles with out_ready tied high.
- All outputs are registered or decoded from state only; there is no combinational path from in_* or out_ready to any output.
- Back-to-back: if out_ready is high in the first DONE cycle, in_ready is high in the next cycle.

## Configuration
- Macro: SHIFT_ITER_ROT_EN.
- Defined: ROL/ROR are supported as above.
- Undefined:
  - ops 000 and 001 are treated as illegal (out_data = in_data, out_err=1, latency T+1).
  - the rotate datapath is removed from the step logic.

## Structure
- Package shift_pkg holds:
  - the op encoding enum (ROL, ROR, SLL, SRA, SRL).
  - the state enum (IDLE, RUN, DONE).
  - the width constants shared with the ALU decode.
- Sub-module shift_step: combinational step (data, op, k∈{1,2}) → data, instantiated once inside shift_iter.
- The FSM, remaining-count and working register stay in shift_iter.

## Test plan
- ROL 0x8001 amt 3, out_ready=1 → out_data 0x000C, out_err 0, out_valid at T+3.
- SRA 0x8000 amt 5 → 0xFC00 at T+4; SRL 0xF000 amt 4 → 0x0F00 at T+3; ROR 0x0001 amt 15 → 0x0002 at T+9.
- SLL 0x1234 amt 0 → 0x1234 at T+1; op 3'b110 with data 0xBEEF → 0xBEEF, out_err 1 at T+1; without SHIFT_ITER_ROT_EN, ROL → out_err 1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_data stable, in_ready 0, a new in_valid is not accepted; on release, in_ready 1 on the following cycle.
- Reset asserted mid-RUN (SLL amt 9, after 2 cycles) → all outputs reach reset values immediately; after release, a new request SLL 0x0001 amt 1 → 0x0002 at T+2.
- Random ops/amounts (1000 requests, random out_ready) → results match a reference shift model, and latency matches the formula.
